grf_wb_arbiter: RTL

Write-port arbiter and scoreboard for the 32x32 general register file, which has a single write port (A3/WD/WE/WPC).
- Merges the in-order pipeline writeback stream with results from the multi-cycle unit (MDU).
- Buffers MDU results in a small FIFO and drives the register-file write port from registered outputs.
- Tracks destination registers with an outstanding MDU write, so decode can stall on RAW hazards.

---
 rtl/grf_wb_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - register-file write-port arbiter with MDU result FIFO and busy scoreboard
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   pipe_we/addr/data/pc     in-order pipeline writeback (never stalled, wins arbitration)
//   mdu_valid/ready/addr/... multi-cycle unit result handshake into the FIFO
//   iss_valid/iss_addr       MDU issue, marks the destination register busy
//   rs_addr/rt_addr          decode source registers; rs_busy/rt_busy report pending MDU writes
//   hold_req                 upstream must keep pipe_we low next cycle so the full FIFO can drain
//   grf_we/a3/wd/wpc         registered register-file write port
//   buf_count                FIFO occupancy
module grf_wb_arbiter #(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_we,
    input  logic [4:0]       pipe_addr,
    input  logic [31:0]      pipe_data,
    input  logic [31:0]      pipe_pc,
    input  logic             mdu_valid,
    output logic             mdu_ready,
    input  logic [4:0]       mdu_addr,
    input  logic [31:0]      mdu_data,
    input  logic [31:0]      mdu_pc,
    input  logic             iss_valid,
    input  logic [4:0]       iss_addr,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic             rs_busy,
    output logic             rt_busy,
    output logic             hold_req,
    output logic             grf_we,
    output logic [4:0]       grf_a3,
    output logic [31:0]      grf_wd,
    output logic [31:0]      grf_wpc,
    output logic [CNT_W-1:0] buf_count
);

    localparam int                PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);

    logic [4:0]       fifo_addr [BUF_DEPTH];
    logic [31:0]      fifo_data [BUF_DEPTH];
    logic [31:0]      fifo_pc   [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      busy;
    logic [31:0]      busy_next;
    logic             pipe_req;
    logic             push;
    logic             pop;
    logic [4:0]       head_addr;

    // Ready depends only on registered occupancy: a pop in the same cycle does
    // not free a slot for the incoming result.
    assign mdu_ready  = (count < DEPTH_C);
    assign pipe_req   = pipe_we && (pipe_addr != 5'd0);
    // $0 results complete the handshake but are dropped.
    assign push       = mdu_valid && mdu_ready && (mdu_addr != 5'd0);
    // Only entries already stored at the start of the cycle can be popped.
    assign pop        = !pipe_req && (count != '0);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign head_addr  = fifo_addr[rd_ptr];
    assign buf_count  = count;

    assign rs_busy = (rs_addr != 5'd0) && busy[rs_addr];
    assign rt_busy = (rt_addr != 5'd0) && busy[rt_addr];

    // Clear before set so an issue to the address being retired stays busy.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[head_addr] = 1'b0;
        end
        if (iss_valid && (iss_addr != 5'd0)) begin
            busy_next[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mdu_addr;
            fifo_data[wr_ptr] <= mdu_data;
            fifo_pc[wr_ptr]   <= mdu_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            busy     <= '0;
            hold_req <= 1'b0;
            grf_we   <= 1'b0;
            grf_a3   <= 5'd0;
            grf_wd   <= 32'd0;
            grf_wpc  <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            busy     <= busy_next;
            hold_req <= (count_next == DEPTH_C);
            if (pipe_req) begin
                grf_we  <= 1'b1;
                grf_a3  <= pipe_addr;
                grf_wd  <= pipe_data;
                grf_wpc <= pipe_pc;
            end else if (pop) begin
                grf_we  <= 1'b1;
                grf_a3  <= head_addr;
                grf_wd  <= fifo_data[rd_ptr];
                grf_wpc <= fifo_pc[rd_ptr];
            end else begin
                grf_we  <= 1'b0;
            end
        end
    end

endmodule
